// File: rtl/prio_enc_rr_n_if.sv
//------------------------------------------------------------------------------
// Module   : prio_enc_rr_n_if
// Purpose  : Request/grant bundle between event sources and the encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface prio_enc_rr_n_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ack;
  logic [W-1:0] q;
  logic         v;
  logic [N-1:0] pending;

  // master = sources plus consumer, slave = the encoder
  modport master (
    output req,
    output mask,
    output ack,
    input  q,
    input  v,
    input  pending
  );

  modport slave (
    input  req,
    input  mask,
    input  ack,
    output q,
    output v,
    output pending
  );
endinterface

`default_nettype wire

// File: rtl/prio_enc_rr_n.sv
//------------------------------------------------------------------------------
// Module   : prio_enc_rr_n
// Purpose  : Sticky N-channel request capture with masked fixed-priority or
//            round-robin encoding, presented under a valid/ack handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prio_enc_rr_n #(
  parameter int N       = 8,
  parameter bit RR_MODE = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  prio_enc_rr_n_if.slave bus
);

  localparam int           W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_pending;
  logic [W-1:0] r_q;
  logic         r_v;

  logic         w_fire;
  logic         w_load;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_elig;
  logic         w_any;
  logic [W-1:0] w_ptr;
  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;
  logic         w_lo_hit;
  logic [W-1:0] w_sel;

  assign w_fire = r_v & bus.ack;
  assign w_load = ~r_v | w_fire;
  assign w_clr  = w_fire ? (c_one << r_q) : '0;
  assign w_elig = r_pending & bus.mask & ~w_clr;
  assign w_any  = |w_elig;

  // Highest eligible index overall, and highest eligible index strictly below
  // the pointer. Round-robin order ptr-1..0 then N-1..ptr prefers the latter;
  // with ptr=0 the lower set is empty and this degenerates to fixed priority.
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_lo_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_elig[i]) begin
        w_hi = W'(i);
        if (i < int'(w_ptr)) begin
          w_lo     = W'(i);
          w_lo_hit = 1'b1;
        end
      end
    end
    w_sel = w_lo_hit ? w_lo : w_hi;
  end

  generate
    if (RR_MODE) begin : g_rr
      logic [W-1:0] r_ptr;

      // The channel just acknowledged becomes the lowest-priority one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_fire) begin
          r_ptr <= r_q;
        end
      end

      assign w_ptr = r_ptr;
    end else begin : g_fixed
      assign w_ptr = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_q       <= '0;
      r_v       <= 1'b0;
    end else begin
      // A request on the channel being acknowledged this cycle survives.
      r_pending <= (r_pending & ~w_clr) | bus.req;
      if (w_load) begin
        r_v <= w_any;
        r_q <= w_any ? w_sel : '0;
      end
    end
  end

  assign bus.q       = r_q;
  assign bus.v       = r_v;
  assign bus.pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_rr_n.sv
//------------------------------------------------------------------------------
// Module   : tb_prio_enc_rr_n
// Purpose  : Directed vector bench driving a fixed and a round-robin encoder
//            side by side with identical stimulus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prio_enc_rr_n;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] q0;
    logic       v0;
    logic [2:0] q1;
    logic       v1;
    logic [7:0] p;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;

  int checks;
  int failures;

  vec_t vq[$];

  prio_enc_rr_n_if #(.N(8)) if_fix ();
  prio_enc_rr_n_if #(.N(8)) if_rr  ();

  assign if_fix.req  = req;
  assign if_fix.mask = mask;
  assign if_fix.ack  = ack;
  assign if_rr.req   = req;
  assign if_rr.mask  = mask;
  assign if_rr.ack   = ack;

  prio_enc_rr_n #(.N(8), .RR_MODE(1'b0)) u_fix (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fix)
  );

  prio_enc_rr_n #(.N(8), .RR_MODE(1'b1)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] q0, input logic v0,
                         input logic [2:0] q1, input logic v1, input logic [7:0] p);
    chk({tag, " fix.q"},       {5'b0, if_fix.q},     {5'b0, q0});
    chk({tag, " fix.v"},       {7'b0, if_fix.v},     {7'b0, v0});
    chk({tag, " fix.pending"}, if_fix.pending,       p);
    chk({tag, " rr.q"},        {5'b0, if_rr.q},      {5'b0, q1});
    chk({tag, " rr.v"},        {7'b0, if_rr.v},      {7'b0, v1});
    chk({tag, " rr.pending"},  if_rr.pending,        p);
  endtask

  task automatic do_reset();
    req   = 8'h00;
    mask  = 8'hFF;
    ack   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input bit r, input logic [7:0] rq, input logic [7:0] mk,
                     input logic a, input logic [2:0] q0, input logic v0,
                     input logic [2:0] q1, input logic v1, input logic [7:0] p);
    vec_t t;
    t.rst = r;  t.req = rq; t.mask = mk; t.ack = a;
    t.q0  = q0; t.v0  = v0; t.q1   = q1; t.v1  = v1; t.p = p;
    vq.push_back(t);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ack while idle must neither clear pending[0] nor hide it from elig
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    add(1'b0, 8'h01, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h01);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 8'h01);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    // one-cycle burst drains 5, 2, 1
    add(1'b1, 8'h26, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h26);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 8'h26);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 8'h06);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 8'h02);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    // hold under ack=0, later request must not preempt
    add(1'b1, 8'h08, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h08);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 8'h08);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 8'h08);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 8'h08);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 8'h08);
    add(1'b0, 8'h80, 8'hFF, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 8'h88);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 8'h88);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 8'h80);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    // all requests held: fixed alternates 7/6, round-robin rotates
    add(1'b1, 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd5, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd3, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd2, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd0, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 8'hFF);
    // masked channel 6 stays pending until unmasked
    add(1'b1, 8'h50, 8'hBF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h50);
    add(1'b0, 8'h00, 8'hBF, 1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 8'h50);
    add(1'b0, 8'h00, 8'hBF, 1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 8'h50);
    add(1'b0, 8'h00, 8'hBF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h40);
    add(1'b0, 8'h00, 8'hBF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h40);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd6, 1'b1, 3'd6, 1'b1, 8'h40);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    // leave rr ptr at 7 and present q=5 with pending=8'h21
    add(1'b1, 8'h80, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h80);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd7, 1'b1, 3'd7, 1'b1, 8'h80);
    add(1'b0, 8'h21, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'h21);
    add(1'b0, 8'h00, 8'hFF, 1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 8'h21);

    rst_n = 1'b0;
    req   = 8'hFF;
    mask  = 8'hFF;
    ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    rst_n = 1'b1;
    req   = 8'h00;

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      req  = vq[i].req;
      mask = vq[i].mask;
      ack  = vq[i].ack;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].q0, vq[i].v0, vq[i].q1, vq[i].v1, vq[i].p);
    end

    // asynchronous reset between edges must clear outputs before any edge
    req  = 8'h00;
    ack  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 3'd0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b1;
    req   = 8'h81;
    @(posedge clk);
    #1;
    chk_all("post_rst_cap", 3'd0, 1'b0, 3'd0, 1'b0, 8'h81);
    req = 8'h00;
    @(posedge clk);
    #1;
    chk_all("post_rst_ptr", 3'd7, 1'b1, 3'd7, 1'b1, 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prio_enc_rr_n.md
Name: prio_enc_rr_n

Overview:
- Parametrised, registered successor to the 4-to-2 priority encoder.
- N request lines are captured into a sticky pending register, qualified by a per-channel mask, and encoded to a binary index. The index is held under a valid/ack handshake until consumed.
- Fixed priority (highest index wins) or round-robin mode. Sits between interrupt/event sources and a single consumer (sequencer, CPU-side handler).

Parameters:
- N, 8, number of request channels; legal range 2..64.
- W, $clog2(N), index width; derived localparam, not overridable.
- RR_MODE, 0, arbitration mode: 0 = fixed priority (index N-1 highest, 0 lowest); 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request bits; any bit high at a clock edge sets the matching pending bit (a one-cycle pulse is sufficient)
- mask  input  N  channel enable; 1 = channel may be granted
- ack  input  1  consumer accepts the current q; effective only when v=1
- q  output  W  registered index of the granted channel
- v  output  1  registered valid; q is meaningful only when v=1
- pending  output  N  registered sticky pending bits, for observability

Behaviour:
- Reset (async, rst_n=0): pending=0, q=0, v=0, RR pointer ptr=0. Outputs take their reset values immediately, without waiting for a clock edge.
- Definitions:
  - fire = v & ack.
  - clr = fire ? onehot(q) : 0.
  - elig = pending & mask & ~clr.
- Pending update at each edge: pending <= (pending & ~clr) | req. A req on the acked channel in the same cycle wins, so that bit stays set.
- Output load condition: load = ~v | fire. The output holds when v=1 and ack=0.
- On a load edge:
  - v <= |elig.
  - q <= selected index when elig != 0; otherwise q <= 0.
  - Same-cycle req is not in elig; it reaches the output only through pending.
- Hold: while v=1 and ack=0, q and v stay stable. Mask changes and new requests never retract or change a presented grant.
- Fixed mode (RR_MODE=0): select the highest set index of elig.
- Round-robin mode (RR_MODE=1):
  - Priority order is ptr-1, ptr-2, ..., 0, N-1, ..., ptr (modulo N).
  - On fire, ptr <= q.
  - With ptr=0 the order is N-1..0, identical to fixed mode.
  - A channel just granted is lowest priority next.
- Latency:
  - A req sampled at edge t sets pending at t. v can rise at edge t+1 if the output is loadable.
  - Back-to-back grants are possible every cycle while ack=1.
- Boundary conditions:
  - ack with v=0: ignored; no clear, no ptr change.
  - elig=0 on a load edge: v <= 0, q <= 0.
  - Masked pending bits remain pending indefinitely and become eligible on the load after unmasking.
  - Fixed mode with a channel held on req: that channel is excluded for one load after each ack, because clr removes it from elig. Continuous req on channels 7 and 6 therefore alternates 7, 6, 7, ...
  - ptr wraps modulo N. Non-power-of-2 N must never select an index >= N.
  - Reset mid-handshake: the grant is dropped with no clear side effects carried over.

Test Plan:
1. Reset: hold rst_n=0 with req=8'hFF -> q=0, v=0, pending=0. Release, drive req=0 -> v stays 0.
2. Fixed, N=8, mask=8'hFF, ack=1: pulse req=8'b0010_0110 for one cycle -> v rises one edge after capture. q sequence is 5, 2, 1 on consecutive cycles, then v=0 and pending=0.
3. Hold: pulse req bit 3, ack=0 for 5 cycles -> q=3, v=1 stable. Pulse req bit 7 during the hold -> q stays 3. Assert ack for one cycle -> next q=7, then v=0 after a second ack.
4. Mode comparison, req=8'hFF held, ack=1:
   - RR_MODE=1 -> q = 7, 6, 5, 4, 3, 2, 1, 0, 7, ...
   - RR_MODE=0 -> q = 7, 6, 7, 6, ...
5. Mask: pending bits 4 and 6 set, mask=8'b1011_1111 -> q=4. After ack, set mask=8'hFF -> q=6. Bit 6 is never granted while masked.
6. Async reset mid-operation: with v=1, q=5, pending=8'h21, pull rst_n low between edges -> v=0, q=0, pending=0 before the next edge. ptr=0 after release, so the first RR grant of req=8'h81 is 7.
